// File: rtl/bht_sat_predictor.sv
// bht_sat_predictor
//   PC-indexed branch history table of CNT_W-bit saturating counters, held
//   in flops. A lookup returns a registered prediction one cycle later; a
//   resolved-branch update moves the indexed counter one step toward the
//   actual outcome, saturating at both ends.
//
// Handshake: pred_req is a valid-only strobe (no ready; every asserted cycle
//   is accepted unless rst is high). pred_valid is the matching response
//   valid, high exactly one cycle after an accepted pred_req, with no
//   backpressure. upd_en is a valid-only strobe, always accepted when rst=0.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   pred_req   in   lookup request
//   pred_pc    in   PC to predict (index = pc[IDX_W+1:2])
//   pred_valid out  registered response valid
//   pred_taken out  registered prediction (counter MSB)
//   pred_cnt   out  registered raw counter value
//   upd_en     in   update strobe
//   upd_pc     in   PC of the resolved branch
//   upd_taken  in   resolved outcome, 1 = taken
module bht_sat_predictor #(
    parameter int CNT_W = 2,
    parameter int IDX_W = 6,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_req,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [CNT_W-1:0] pred_cnt,
    input  logic             upd_en,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken
);

    localparam int               DEPTH   = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // Weakly not-taken: 0111..1 (just below the taken threshold).
    localparam logic [CNT_W-1:0] RST_CNT = CNT_MAX >> 1;

    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cnt_d [DEPTH];

    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [CNT_W-1:0] pred_cnt_q,   pred_cnt_d;

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CNT_W-1:0] upd_old;
    logic [CNT_W-1:0] upd_new;

    // Byte-offset bits and bits above the index are deliberately ignored
    // (aliasing is allowed); fold them into one sink so the intent is visible.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, upd_pc};

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_old  = cnt_q[upd_idx];

    // Saturating step toward the resolved outcome.
    always_comb begin
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != CNT_MAX) upd_new = upd_old + 1'b1;
        end else begin
            if (upd_old != '0) upd_new = upd_old - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (upd_en) cnt_d[upd_idx] = upd_new;
    end

    // Reading the lookup from cnt_d (not cnt_q) gives write-first bypass
    // when the update and the lookup hit the same index in one cycle.
    always_comb begin
        pred_valid_d = pred_req;
        pred_taken_d = pred_taken_q;
        pred_cnt_d   = pred_cnt_q;
        if (pred_req) begin
            pred_cnt_d   = cnt_d[pred_idx];
            pred_taken_d = cnt_d[pred_idx][CNT_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= RST_CNT;
            end
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_cnt_q   <= pred_cnt_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_cnt   = pred_cnt_q;

endmodule

// File: doc/bht_sat_predictor.md
Name: bht_sat_predictor

Overview:
- Parametrised branch history table (BHT) of N-bit saturating counters.
- Generalises the single 2-bit predictor FSM to a PC-indexed table with configurable counter width and depth.
- Sits in the IF stage: a registered taken/not-taken prediction per fetched PC.
- Updated from EX/MEM with the resolved branch outcome.

Parameters:
- CNT_W, 2, counter width in bits; must be >= 1.
- IDX_W, 6, log2 of table depth (64 entries).
- PC_W, 32, program counter width; must be >= IDX_W+2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pred_req  input  1  prediction lookup request this cycle.
- pred_pc  input  PC_W  PC of the instruction being predicted.
- pred_valid  output  1  registered; high one cycle after an accepted pred_req.
- pred_taken  output  1  registered prediction (counter MSB).
- pred_cnt  output  CNT_W  registered raw counter value for the looked-up entry.
- upd_en  input  1  resolved-branch update strobe.
- upd_pc  input  PC_W  PC of the resolved branch.
- upd_taken  input  1  actual outcome: 1 = taken, 0 = not taken.

Behaviour:
- Index: idx(pc) = pc[IDX_W+1:2]. Bits [1:0] are ignored. Higher bits are ignored, so aliasing is permitted.
- Table: 2^IDX_W counters of CNT_W bits, held in flops. No SRAM.
- Reset value of every counter: RST_CNT = 2^(CNT_W-1) - 1 (weakly not-taken). For CNT_W=2 this is 01; for CNT_W=1 it is 0.
- Reset timing:
  - rst high at an edge loads all counters with RST_CNT and clears pred_valid, pred_taken and pred_cnt to 0.
  - pred_req and upd_en are ignored in any cycle where rst is high.
  - Reset completes in one cycle. The first lookup after rst falls sees RST_CNT.
- Update, on an edge with upd_en=1 and rst=0, applied to cnt[idx(upd_pc)]:
  - upd_taken=1: if cnt == 2^CNT_W-1, hold; else cnt+1.
  - upd_taken=0: if cnt == 0, hold; else cnt-1.
  - No wrap-around in either direction.
  - All other entries are unchanged.
- Lookup latency is 1 cycle:
  - A pred_req at edge t produces, after edge t: pred_valid=1, pred_cnt = entry value, pred_taken = pred_cnt[CNT_W-1].
  - Outputs hold until the next edge.
  - pred_req=0 at an edge drives pred_valid=0; pred_taken and pred_cnt keep their last values.
- Read/update collision: if pred_req and upd_en are both active in the same cycle with idx(pred_pc) == idx(upd_pc), the lookup returns the post-update value (write-first bypass).
- A lookup and an update to different indices in the same cycle are independent.
- Back-to-back updates to the same index accumulate, one step per cycle.
- Stall handling is the consumer's job. The block has no stall input, and every pred_req cycle performs a new lookup.

Test Plan:
- Reset: rst=1 for 2 cycles, then lookup pred_pc=0x0000_0040 -> pred_valid=1, pred_cnt=01, pred_taken=0 one cycle later. While rst is high, pred_valid=0 and pred_cnt=00.
- Saturate up (CNT_W=2): three upd_taken=1 updates at 0x40, then lookup -> pred_cnt sequence 10, 11, 11 and pred_taken=1. Four upd_taken=0 updates -> 10, 01, 00, 00 and pred_taken=0.
- Aliasing: 2 taken updates at 0x040, then lookup 0x140 (same idx 0x10) -> pred_cnt=11. Lookup 0x044 (idx 0x11) -> pred_cnt=01.
- Collision bypass: entry idx 0x10 = 01; same cycle pred_req/pred_pc=0x40 and upd_en/upd_pc=0x40/upd_taken=1 -> pred_cnt=10, pred_taken=1 next cycle. With upd_pc=0x44 instead -> pred_cnt=01.
- Reset mid-operation: drive entry 0x40 to 11, then assert rst together with upd_en (taken) -> update ignored, entry returns to 01, pred_valid=0. A subsequent lookup returns 01.
- Parameter sweep: CNT_W=3, IDX_W=4 -> reset value 011. Five taken updates -> 100, 101, 110, 111, 111; pred_taken rises at 100. Index uses pc[5:2], so pc 0x0 and 0x40 alias.
